// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Fetches from a variable-latency imem over req/ready, honours hazard freeze
// and EXE branch redirect. Optional macro IF_STALL_CNT_EN enables the imem
// wait-cycle counter on stall_cycles (tied to zero otherwise).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    Branch_taken,
    input  logic [31:0]             Branch_Address,
    if_fetch_stage_if.master        imem,
    output logic [31:0]             PC,
    output logic [31:0]             Instruction,
    output logic                    valid,
    output logic [31:0]             stall_cycles
);

    localparam int unsigned XLEN = 32;

    // FETCH: requesting at pc; HOLD: word parked during freeze;
    // DRAIN: finishing an abandoned request after a redirect.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_nxt;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   hold_buf;
    logic [XLEN-1:0]   hold_buf_nxt;
    logic [XLEN-1:0]   drain_addr;
    logic [XLEN-1:0]   drain_addr_nxt;
    logic [XLEN-1:0]   pc_out_nxt;
    logic [XLEN-1:0]   instr_nxt;
    logic              valid_nxt;
    logic              xfer;

    // Request is a pure function of state and is dropped during reset.
    assign imem.req  = rst && (state != HOLD);
    assign imem.addr = (state == DRAIN) ? drain_addr : pc;
    assign xfer      = imem.req && imem.ready;
    assign pc_plus4  = pc + XLEN'(4);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            hold_buf    <= '0;
            drain_addr  <= '0;
            PC          <= '0;
            Instruction <= NOP_WORD;
            valid       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            hold_buf    <= hold_buf_nxt;
            drain_addr  <= drain_addr_nxt;
            PC          <= pc_out_nxt;
            Instruction <= instr_nxt;
            valid       <= valid_nxt;
        end
    end

    // Next-state and next-register values; branch beats freeze and transfers.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        hold_buf_nxt   = hold_buf;
        drain_addr_nxt = drain_addr;
        pc_out_nxt     = PC;
        instr_nxt      = Instruction;
        valid_nxt      = valid;

        case (state)
            FETCH: begin
                if (Branch_taken) begin
                    pc_nxt    = Branch_Address;
                    instr_nxt = NOP_WORD;
                    valid_nxt = 1'b0;
                    if (!imem.ready) begin
                        drain_addr_nxt = pc;
                        state_nxt      = DRAIN;
                    end
                end else if (xfer) begin
                    pc_nxt = pc_plus4;
                    if (!freeze) begin
                        instr_nxt  = imem.rdata;
                        pc_out_nxt = pc_plus4;
                        valid_nxt  = 1'b1;
                    end else begin
                        hold_buf_nxt = imem.rdata;
                        state_nxt    = HOLD;
                    end
                end else if (!freeze) begin
                    instr_nxt = NOP_WORD;
                    valid_nxt = 1'b0;
                end
            end

            HOLD: begin
                if (Branch_taken) begin
                    pc_nxt    = Branch_Address;
                    instr_nxt = NOP_WORD;
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end else if (!freeze) begin
                    instr_nxt  = hold_buf;
                    pc_out_nxt = pc;
                    valid_nxt  = 1'b1;
                    state_nxt  = FETCH;
                end
            end

            DRAIN: begin
                instr_nxt = NOP_WORD;
                valid_nxt = 1'b0;
                if (Branch_taken) begin
                    pc_nxt = Branch_Address;
                end
                if (xfer) begin
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

`ifdef IF_STALL_CNT_EN
    logic [XLEN-1:0] stall_cnt;

    // Saturating count of cycles spent waiting on imem.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (imem.req && !imem.ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + XLEN'(1);
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random
// freeze/branch/ready traffic against a transaction-level reference model.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        rdy;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic [31:0] stall_o;

    int err_cnt;
    int chk_cnt;

    if_fetch_stage_if imem ();

    if_fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_WORD (NOP_WORD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .Branch_taken   (branch_taken),
        .Branch_Address (branch_address),
        .imem           (imem),
        .PC             (pc_o),
        .Instruction    (instr_o),
        .valid          (valid_o),
        .stall_cycles   (stall_o)
    );

    // Memory contents: address-derived word, distinct from address and PC+4.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    assign imem.ready = rdy;
    assign imem.rdata = mem_word(imem.addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural pc, presented triple, parked words and
    // outstanding abandoned requests.
    logic [31:0] m_pc;
    logic [31:0] m_pco;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [31:0] m_stall;
    logic [31:0] parked[$];
    logic [31:0] abandoned[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_pco   = 32'h0;
        m_instr = NOP_WORD;
        m_valid = 1'b0;
        m_stall = 32'h0;
        parked.delete();
        abandoned.delete();
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".PC"}, pc_o, m_pco);
        check_val({tag, ".Instruction"}, instr_o, m_instr);
        check_val({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
`ifdef IF_STALL_CNT_EN
        check_val({tag, ".stall"}, stall_o, m_stall);
`else
        check_val({tag, ".stall"}, stall_o, 32'h0);
`endif
    endtask

    // One clock: drive inputs, check request side, step model, check IF/ID.
    task automatic cycle(input logic f, input logic bt, input logic [31:0] ba, input logic r);
        logic        e_req;
        logic [31:0] e_addr;
        logic        xf;
        logic [31:0] w;
        freeze         = f;
        branch_taken   = bt;
        branch_address = ba;
        rdy            = r;
        #1;
        e_req  = (parked.size() == 0);
        e_addr = (abandoned.size() != 0) ? abandoned[0] : m_pc;
        check_val("req", 32'(imem.req), 32'(e_req));
        if (e_req) check_val("addr", imem.addr, e_addr);

        xf = e_req && r;
        if (e_req && !r && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
        if (abandoned.size() != 0) begin
            if (bt) m_pc = ba;
            if (xf) void'(abandoned.pop_front());
            m_instr = NOP_WORD;
            m_valid = 1'b0;
        end else if (parked.size() != 0) begin
            if (bt) begin
                m_pc = ba;
                parked.delete();
                m_instr = NOP_WORD;
                m_valid = 1'b0;
            end else if (!f) begin
                m_instr = parked.pop_front();
                m_pco   = m_pc;
                m_valid = 1'b1;
            end
        end else begin
            if (bt) begin
                if (!r) abandoned.push_back(m_pc);
                m_pc    = ba;
                m_instr = NOP_WORD;
                m_valid = 1'b0;
            end else if (xf) begin
                w    = mem_word(m_pc);
                m_pc = m_pc + 32'd4;
                if (!f) begin
                    m_instr = w;
                    m_pco   = m_pc;
                    m_valid = 1'b1;
                end else begin
                    parked.push_back(w);
                end
            end else if (!f) begin
                m_instr = NOP_WORD;
                m_valid = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        check_outputs("out");
    endtask

    // Assert reset away from the edge, check it acts at once, release after an edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_val("rst.req", 32'(imem.req), 32'h0);
        check_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        err_cnt        = 0;
        chk_cnt        = 0;
        rst            = 1'b0;
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_address = 32'h0;
        rdy            = 1'b0;
        #3;
        do_reset();

        // Zero-wait streaming from reset.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        // Two wait cycles at 0x10.
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        // Freeze while the word at 0x20 returns.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        // Branch with freeze during a pending wait at 0x30 -> DRAIN.
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h100, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        // PC wrap at the top of the address space.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        // Reset mid-DRAIN.
        cycle(1'b0, 1'b1, 32'h200, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic        f;
            logic        bt;
            logic        r;
            logic [31:0] ba;
            f  = ($urandom_range(0, 9) < 3);
            bt = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 9) < 6);
            ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
            cycle(f, bt, ba, r);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
